// File: rtl/fs_fifo.sv
// Single-clock FIFO buffering read data between the Wishbone and QSPI sides of the bridge.
// Define FS_FIFO_ERR_FLAGS_EN to add sticky overflow_o/underflow_o error outputs.
module fs_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     wr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
`ifdef FS_FIFO_ERR_FLAGS_EN
  output logic                     overflow_o,
  output logic                     underflow_o,
`endif
  output logic [$clog2(DEPTH):0]   filled_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             push;
  logic             pop;

  // Acceptance is decided from the pre-edge count, so a same-edge pop never frees room for a push.
  assign full_o  = (filled_o == CW'(DEPTH));
  assign empty_o = (filled_o == '0);
  assign push    = wr_i && !full_o;
  assign pop     = rd_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (reset_ni && push) begin
      mem[wptr] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      wptr      <= '0;
      rptr      <= '0;
      filled_o  <= '0;
      rd_data_o <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rd_data_o <= mem[rptr];
        rptr      <= rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   filled_o <= filled_o + 1'b1;
        2'b01:   filled_o <= filled_o - 1'b1;
        default: filled_o <= filled_o;
      endcase
    end
  end

`ifdef FS_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (wr_i && full_o) begin
        overflow_o <= 1'b1;
      end
      if (rd_i && empty_o) begin
        underflow_o <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fs_fifo.sv
// Directed self-checking bench for fs_fifo; honours FS_FIFO_ERR_FLAGS_EN when defined.
module tb_fs_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;

  logic             clk_i = 1'b0;
  logic             reset_ni;
  logic             wr_i;
  logic [WIDTH-1:0] wr_data_i;
  logic             rd_i;
  logic [WIDTH-1:0] rd_data_o;
  logic             full_o;
  logic             empty_o;
  logic [4:0]       filled_o;
`ifdef FS_FIFO_ERR_FLAGS_EN
  logic             overflow_o;
  logic             underflow_o;
`endif

  int checks = 0;
  int failures = 0;

  fs_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .wr_i       (wr_i),
    .wr_data_i  (wr_data_i),
    .rd_i       (rd_i),
    .rd_data_o  (rd_data_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
`ifdef FS_FIFO_ERR_FLAGS_EN
    .overflow_o (overflow_o),
    .underflow_o(underflow_o),
`endif
    .filled_o   (filled_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    reset_ni = 1'b0; wr_i = 1'b0; rd_i = 1'b0; wr_data_i = '0;
    step();
    step();
    checks++;
    if (filled_o !== 5'd0) begin failures++; $display("[TB] FAIL reset_filled got=%0d exp=0", filled_o); end
    checks++;
    if (empty_o !== 1'b1 || full_o !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_flags got empty=%b full=%b exp empty=1 full=0", empty_o, full_o);
    end
    checks++;
    if (rd_data_o !== 16'h0000) begin failures++; $display("[TB] FAIL reset_rd_data got=%h exp=0000", rd_data_o); end
  endtask

  task automatic test_fill();
    reset_ni = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      wr_i = 1'b1; wr_data_i = 16'(i);
      step();
      checks++;
      if (filled_o !== 5'(i) || empty_o !== 1'b0 || full_o !== (i == 16)) begin
        failures++;
        $display("[TB] FAIL fill_%0d got filled=%0d empty=%b full=%b exp filled=%0d empty=0 full=%b",
                 i, filled_o, empty_o, full_o, i, (i == 16));
      end
    end
    wr_i = 1'b0;
  endtask

  task automatic test_overflow();
    wr_i = 1'b1; wr_data_i = 16'hDEAD;
    step();
    wr_i = 1'b0;
    checks++;
    if (filled_o !== 5'd16 || full_o !== 1'b1) begin
      failures++; $display("[TB] FAIL overflow_drop got filled=%0d full=%b exp filled=16 full=1", filled_o, full_o);
    end
`ifdef FS_FIFO_ERR_FLAGS_EN
    checks++;
    if (overflow_o !== 1'b1 || underflow_o !== 1'b0) begin
      failures++; $display("[TB] FAIL overflow_flag got ovf=%b unf=%b exp ovf=1 unf=0", overflow_o, underflow_o);
    end
`endif
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 16; i++) begin
      rd_i = 1'b1;
      step();
      checks++;
      if (rd_data_o !== 16'(i) || filled_o !== 5'(16 - i)) begin
        failures++;
        $display("[TB] FAIL drain_%0d got data=%h filled=%0d exp data=%h filled=%0d",
                 i, rd_data_o, filled_o, 16'(i), 16 - i);
      end
    end
    rd_i = 1'b0;
    step();
    checks++;
    if (rd_data_o !== 16'h0010 || empty_o !== 1'b1) begin
      failures++; $display("[TB] FAIL drain_hold got data=%h empty=%b exp data=0010 empty=1", rd_data_o, empty_o);
    end
  endtask

  task automatic test_empty_push_pop();
    rd_i = 1'b1; wr_i = 1'b1; wr_data_i = 16'h00A5;
    step();
    wr_i = 1'b0;
    checks++;
    if (rd_data_o !== 16'h0010 || filled_o !== 5'd1) begin
      failures++; $display("[TB] FAIL empty_rw got data=%h filled=%0d exp data=0010 filled=1", rd_data_o, filled_o);
    end
`ifdef FS_FIFO_ERR_FLAGS_EN
    checks++;
    if (underflow_o !== 1'b1) begin failures++; $display("[TB] FAIL underflow_flag got=%b exp=1", underflow_o); end
`endif
    step();
    rd_i = 1'b0;
    checks++;
    if (rd_data_o !== 16'h00A5 || filled_o !== 5'd0 || empty_o !== 1'b1) begin
      failures++; $display("[TB] FAIL empty_rw_pop got data=%h filled=%0d empty=%b exp data=00a5 filled=0 empty=1",
                           rd_data_o, filled_o, empty_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] expected;
    for (int k = 0; k < 8; k++) begin
      wr_i = 1'b1; wr_data_i = 16'h0100 + 16'(k);
      step();
    end
    checks++;
    if (filled_o !== 5'd8) begin failures++; $display("[TB] FAIL b2b_prefill got=%0d exp=8", filled_o); end
    for (int k = 0; k < 40; k++) begin
      wr_i = 1'b1; rd_i = 1'b1; wr_data_i = 16'h0200 + 16'(k);
      step();
      expected = (k < 8) ? 16'h0100 + 16'(k) : 16'h0200 + 16'(k - 8);
      checks++;
      if (rd_data_o !== expected || filled_o !== 5'd8) begin
        failures++;
        $display("[TB] FAIL b2b_%0d got data=%h filled=%0d exp data=%h filled=8", k, rd_data_o, filled_o, expected);
      end
    end
    wr_i = 1'b0; rd_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      rd_i = 1'b1;
      step();
      checks++;
      if (rd_data_o !== 16'h0220 + 16'(k)) begin
        failures++; $display("[TB] FAIL mid_pop_%0d got=%h exp=%h", k, rd_data_o, 16'h0220 + 16'(k));
      end
    end
    rd_i = 1'b0;
    checks++;
    if (filled_o !== 5'd5) begin failures++; $display("[TB] FAIL mid_five got=%0d exp=5", filled_o); end
    reset_ni = 1'b0; wr_i = 1'b1; rd_i = 1'b1; wr_data_i = 16'hBEEF;
    step();
    wr_i = 1'b0; rd_i = 1'b0;
    checks++;
    if (filled_o !== 5'd0 || empty_o !== 1'b1 || full_o !== 1'b0 || rd_data_o !== 16'h0000) begin
      failures++; $display("[TB] FAIL mid_reset got filled=%0d empty=%b full=%b data=%h exp 0/1/0/0000",
                           filled_o, empty_o, full_o, rd_data_o);
    end
`ifdef FS_FIFO_ERR_FLAGS_EN
    checks++;
    if (overflow_o !== 1'b0 || underflow_o !== 1'b0) begin
      failures++; $display("[TB] FAIL mid_reset_flags got ovf=%b unf=%b exp 0 0", overflow_o, underflow_o);
    end
`endif
    reset_ni = 1'b1; rd_i = 1'b1;
    step();
    rd_i = 1'b0;
    checks++;
    if (rd_data_o !== 16'h0000 || filled_o !== 5'd0) begin
      failures++; $display("[TB] FAIL post_reset_pop got data=%h filled=%0d exp data=0000 filled=0", rd_data_o, filled_o);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_empty_push_pop();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fs_fifo.md
Name: fs_fifo

Overview:
- Fully synchronous single-clock FIFO used as the read-data buffer between the Wishbone master side and the QSPI transmit side of the bridge.
- Stores up to DEPTH words and exposes full, empty and fill-count status.
- Read data is registered: it is presented the cycle after a pop.

Parameters:
WIDTH, 16, data word width in bits.
DEPTH, 16, number of storage entries; power of two, at least 2.

Ports:
clk_i  input  1  system clock; all logic on rising edge.
reset_ni  input  1  synchronous active-low reset.
wr_i  input  1  push request.
wr_data_i  input  WIDTH  push data.
rd_i  input  1  pop request.
rd_data_o  output  WIDTH  registered pop data.
full_o  output  1  high when filled_o == DEPTH.
empty_o  output  1  high when filled_o == 0.
filled_o  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (reset_ni low at a clock edge):
  - write pointer = 0, read pointer = 0, filled_o = 0.
  - empty_o = 1, full_o = 0, rd_data_o = 0.
  - Storage array is not cleared.
  - Reset takes priority over any simultaneous wr_i or rd_i.
- Push accepted iff wr_i && !full_o at the edge:
  - mem[wptr] <= wr_data_i.
  - wptr advances modulo DEPTH.
- Pop accepted iff rd_i && !empty_o at the edge:
  - rd_data_o <= mem[rptr].
  - rptr advances modulo DEPTH.
  - Data is visible on rd_data_o in the cycle after the pop edge.
- rd_data_o holds its value on all cycles without an accepted pop.
- Status decisions use the pre-edge filled_o value:
  - Push while full is dropped, even if a pop occurs on the same edge.
  - Pop while empty is ignored, even if a push occurs on the same edge. The pushed word is stored and rd_data_o is unchanged.
- Accepted push and pop on the same edge: filled_o unchanged, both pointers advance.
- filled_o:
  - +1 on push only, -1 on pop only.
  - Never exceeds DEPTH and never underflows.
- full_o and empty_o are decoded combinationally from the registered count; no extra latency.
- Pointer wrap-around is transparent. Data order is strict FIFO across any number of wraps.
- Latency:
  - A word pushed into an empty FIFO can be popped on the next edge.
  - Its data appears on rd_data_o one cycle after that pop.

Optional Feature:
- Macro FS_FIFO_ERR_FLAGS_EN.
- When defined, adds two outputs:
  - overflow_o (1 bit): sticky; set on the edge where wr_i is high while full_o is high.
  - underflow_o (1 bit): sticky; set on the edge where rd_i is high while empty_o is high.
  - Both are cleared only by reset (to 0).
  - Setting a flag has no effect on data or pointers.
- When not defined, these ports and their logic do not exist, and the FIFO behaves identically otherwise.

Test Plan:
1. Reset, then push 0x0001..0x0010 on 16 consecutive cycles -> filled_o steps 1..16; full_o=1 after the 16th edge; empty_o=0.
2. From full, drive wr_i=1 with 0xDEAD -> filled_o stays 16, the word is dropped. With FS_FIFO_ERR_FLAGS_EN, overflow_o=1.
3. Pop 16 times -> rd_data_o shows 0x0001..0x0010, each one cycle after its pop edge; empty_o=1 at the end.
4. From empty, rd_i and wr_i (0x00A5) on the same edge -> rd_data_o unchanged, filled_o=1. Pop on the next edge -> rd_data_o=0x00A5 the cycle after.
5. With 8 entries present, drive simultaneous push/pop for 40 cycles -> filled_o stays 8; output order matches input order across pointer wrap.
6. Assert reset_ni=0 with 5 entries present -> filled_o=0, empty_o=1, full_o=0, rd_data_o=0 the cycle after; a later pop with no push leaves rd_data_o at 0.
